// File: rtl/burst_prio_arbiter_pkg.sv
// Shared types and helpers for the burst-locking fixed-priority arbiter.
// Holds the FSM state enum and the wait-counter width function.
package burst_prio_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Aging disabled (max_wait=0) still needs a legal 1-bit counter vector.
    function automatic int cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/first_one_sel.sv
// Lowest-set-bit selector: one-hot of the lowest set bit plus an any-set flag.
module first_one_sel #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] onehot,
    output logic             any
);

    // Two's complement isolates the lowest set bit.
    assign onehot = vec & (~vec + WIDTH'(1));
    assign any    = |vec;

endmodule

// File: rtl/onehot_to_bin.sv
// One-hot (or zero) vector to binary index; all-zero input yields index 0.
module onehot_to_bin #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] oh,
    output logic [IDX_W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (oh[i]) begin
                bin = bin | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/burst_prio_arbiter.sv
// Fixed-priority arbiter with burst lock and wait-counter aging that shares one
// valid/ready resource port among NUM_REQ requesters.
module burst_prio_arbiter
    import burst_prio_arbiter_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  MAX_WAIT = 7,
    localparam int CNT_W    = cnt_width(MAX_WAIT),
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    input  logic               ready_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               locked_o,
    output logic               starve_o
);

    // Handshake: a beat transfers in any cycle where valid_o and ready_i are
    // both high; valid_o never depends on ready_i, and ready_i may toggle freely.

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);
    localparam bit               AGING_EN = (MAX_WAIT != 0);

    state_e             state_q;
    logic [IDX_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt_q [NUM_REQ];

    logic [NUM_REQ-1:0] aged;
    logic [NUM_REQ-1:0] aged_oh;
    logic [NUM_REQ-1:0] req_oh;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] sel_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               aged_any;
    logic               req_any;
    logic               xfer;

    always_comb begin
        aged = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            aged[i] = req_i[i] & AGING_EN & (cnt_q[i] == MAX_CNT);
        end
    end

    first_one_sel #(.WIDTH(NUM_REQ)) u_aged_sel (
        .vec    (aged),
        .onehot (aged_oh),
        .any    (aged_any)
    );

    first_one_sel #(.WIDTH(NUM_REQ)) u_req_sel (
        .vec    (req_i),
        .onehot (req_oh),
        .any    (req_any)
    );

    // Promoted requesters outrank plain fixed priority.
    assign win_oh = aged_any ? aged_oh : req_oh;

    onehot_to_bin #(.WIDTH(NUM_REQ), .IDX_W(IDX_W)) u_win_bin (
        .oh  (win_oh),
        .bin (win_idx)
    );

    assign sel_oh = NUM_REQ'(1) << sel_q;

    always_comb begin
        if (state_q == LOCKED) begin
            gnt_o    = sel_oh;
            valid_o  = req_i[sel_q];
            idx_o    = sel_q;
            starve_o = 1'b0;
        end else begin
            gnt_o    = win_oh;
            valid_o  = req_any;
            idx_o    = win_idx;
            starve_o = aged_any;
        end
    end

    assign xfer     = valid_o & ready_i;
    assign locked_o = (state_q == LOCKED);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer && !last_i[win_idx]) begin
                        state_q <= LOCKED;
                        sel_q   <= win_idx;
                    end
                end
                LOCKED: begin
                    // Release only; re-arbitration happens in the next IDLE cycle.
                    if (xfer && last_i[sel_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Counters run in both states; a lock is never preempted, promotion only
    // matters at the next IDLE arbitration.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_i || flush_i) begin
                cnt_q[i] <= '0;
            end else if (!req_i[i] || (xfer && gnt_o[i])) begin
                cnt_q[i] <= '0;
            end else if (cnt_q[i] != MAX_CNT) begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_burst_prio_arbiter.sv
// Bench for burst_prio_arbiter: two instances (aging at 3 and aging disabled)
// share stimulus and are compared against a per-instance behavioural model.
module tb_burst_prio_arbiter;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;

    logic [3:0] gnt_a, gnt_b;
    logic       valid_a, valid_b;
    logic [1:0] idx_a, idx_b;
    logic       locked_a, locked_b;
    logic       starve_a, starve_b;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    burst_prio_arbiter #(.NUM_REQ(4), .MAX_WAIT(3)) dut_a (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .req_i    (req),
        .last_i   (last),
        .ready_i  (ready),
        .gnt_o    (gnt_a),
        .valid_o  (valid_a),
        .idx_o    (idx_a),
        .locked_o (locked_a),
        .starve_o (starve_a)
    );

    burst_prio_arbiter #(.NUM_REQ(4), .MAX_WAIT(0)) dut_b (
        .clk_i    (clk),
        .rst_i    (rst),
        .flush_i  (flush),
        .req_i    (req),
        .last_i   (last),
        .ready_i  (ready),
        .gnt_o    (gnt_b),
        .valid_o  (valid_b),
        .idx_o    (idx_b),
        .locked_o (locked_b),
        .starve_o (starve_b)
    );

    // ---------------- reference model ----------------
    int   mw [2] = '{3, 0};
    int   m_wait [2][4];
    bit   m_lock [2];
    int   m_owner [2];
    int   e_win [2];
    logic [3:0] e_gnt [2];
    logic       e_valid [2];
    logic [1:0] e_idx [2];
    logic       e_starve [2];
    bit   model_ok = 1'b0;

    task automatic predict();
        for (int m = 0; m < 2; m++) begin
            int w;
            bit promoted;
            w = -1;
            promoted = 1'b0;
            if (m_lock[m]) begin
                w = m_owner[m];
                e_valid[m] = req[w];
            end else begin
                for (int i = 3; i >= 0; i--)
                    if (req[i] && mw[m] != 0 && m_wait[m][i] >= mw[m]) w = i;
                if (w >= 0) promoted = 1'b1;
                else
                    for (int i = 3; i >= 0; i--) if (req[i]) w = i;
                e_valid[m] = (req != 4'b0000);
            end
            e_win[m]    = w;
            e_gnt[m]    = (w >= 0) ? 4'(1 << w) : 4'b0000;
            e_idx[m]    = (w >= 0) ? 2'(w) : 2'd0;
            e_starve[m] = promoted;
        end
    endtask

    task automatic advance();
        for (int m = 0; m < 2; m++) begin
            bit moved;
            moved = e_valid[m] && ready;
            if (rst || flush) begin
                m_lock[m]  = 1'b0;
                m_owner[m] = 0;
                for (int i = 0; i < 4; i++) m_wait[m][i] = 0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (!req[i] || (moved && e_win[m] == i)) m_wait[m][i] = 0;
                    else if (m_wait[m][i] < mw[m]) m_wait[m][i]++;
                end
                if (!m_lock[m] && moved && !last[e_win[m]]) begin
                    m_lock[m]  = 1'b1;
                    m_owner[m] = e_win[m];
                end else if (m_lock[m] && moved && last[m_owner[m]]) begin
                    m_lock[m] = 1'b0;
                end
            end
        end
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] rq, input logic [3:0] ls, input logic rdy,
                         input logic fl, input logic rs);
        @(negedge clk);
        req = rq; last = ls; ready = rdy; flush = fl; rst = rs;
        #1;
        predict();
        if (model_ok) begin
            check_eq("a_gnt",    32'(gnt_a),    32'(e_gnt[0]));
            check_eq("a_valid",  32'(valid_a),  32'(e_valid[0]));
            check_eq("a_idx",    32'(idx_a),    32'(e_idx[0]));
            check_eq("a_locked", 32'(locked_a), 32'(m_lock[0]));
            check_eq("a_starve", 32'(starve_a), 32'(e_starve[0]));
            check_eq("b_gnt",    32'(gnt_b),    32'(e_gnt[1]));
            check_eq("b_valid",  32'(valid_b),  32'(e_valid[1]));
            check_eq("b_idx",    32'(idx_b),    32'(e_idx[1]));
            check_eq("b_locked", 32'(locked_b), 32'(m_lock[1]));
            check_eq("b_starve", 32'(starve_b), 32'(e_starve[1]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        advance();
    endtask

    task automatic do_reset();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] r_req;
        rst = 1'b1; flush = 1'b0; req = '0; last = '0; ready = 1'b0;
        do_reset();
        do_reset();
        model_ok = 1'b1;

        // Reset state: nothing requested, everything low.
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        check_eq("rst_gnt", 32'(gnt_a), 32'h0);
        check_eq("rst_locked", 32'(locked_a), 32'h0);
        tick();

        // Priority: lowest requesting index wins, single beats never lock.
        drive(4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0);
        check_eq("prio_gnt", 32'(gnt_a), 32'h2);
        check_eq("prio_idx", 32'(idx_a), 32'h1);
        tick();
        drive(4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0);
        check_eq("prio_nolock", 32'(locked_a), 32'h0);
        tick();

        // Burst lock on port 2 while port 0 joins mid-burst.
        do_reset();
        drive(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0); check_eq("burst_b1", 32'(gnt_a), 32'h4); tick();
        for (int b = 2; b <= 4; b++) begin
            drive(4'b0101, (b == 4) ? 4'b0100 : 4'b0000, 1'b1, 1'b0, 1'b0);
            check_eq("burst_gnt", 32'(gnt_a), 32'h4);
            check_eq("burst_lock", 32'(locked_a), 32'h1);
            tick();
        end
        drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
        check_eq("burst_after", 32'(gnt_a), 32'h1);
        check_eq("burst_unlock", 32'(locked_a), 32'h0);
        tick();

        // Backpressure: no lock forms without an accepted beat.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
            if (c < 3) check_eq("bp_gnt", 32'(gnt_a), 32'h1);
            check_eq("bp_nolock", 32'(locked_a), 32'h0);
            tick();
        end

        // Starvation: port 3 promoted on its 4th arbitration; never with aging off.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(4'b1001, 4'b1111, 1'b1, 1'b0, 1'b0);
            if (c == 3) begin
                check_eq("starve_gnt", 32'(gnt_a), 32'h8);
                check_eq("starve_flag", 32'(starve_a), 32'h1);
            end
            if (c == 4) check_eq("starve_clr", 32'(gnt_a), 32'h1);
            check_eq("noage_gnt", 32'(gnt_b), 32'h1);
            check_eq("noage_starve", 32'(starve_b), 32'h0);
            tick();
        end

        // Flush mid-burst drops the lock and clears counters.
        do_reset();
        drive(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0); tick();
        drive(4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0);
        check_eq("flush_pre", 32'(locked_a), 32'h1);
        tick();
        drive(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_eq("flush_lock", 32'(locked_a), 32'h0);
        check_eq("flush_gnt", 32'(gnt_a), 32'h1);
        check_eq("flush_starve", 32'(starve_a), 32'h0);
        tick();

        // Randomized phase: slowly changing requests so aging gets exercised.
        r_req = 4'b0000;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) r_req[$urandom_range(0, 3)] ^= 1'b1;
            drive(r_req, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 255) == 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
